// File: rtl/data_route_bridge_pkg.sv
// Shared widths, size encodings, uncached FSM states and request payload for data_route_bridge.
// Optional feature macro: UNCACHE_WBUF_EN (adds the U_ACK state for posted uncached stores).
package data_route_bridge_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SZW = 2;
  localparam int unsigned SBW = 4;

  localparam logic [SZW-1:0] SIZE_B = 2'd0;
  localparam logic [SZW-1:0] SIZE_H = 2'd1;
  localparam logic [SZW-1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_REQ  = 2'd1,
`ifdef UNCACHE_WBUF_EN
    U_WAIT = 2'd2,
    U_ACK  = 2'd3
`else
    U_WAIT = 2'd2
`endif
  } u_state_t;

  typedef struct packed {
    logic           wr;
    logic [SZW-1:0] size;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [SBW-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/data_route_bridge_uncache_req_ctrl.sv
// Uncached request capture and single-beat replay on the ub_* sram-like port.
// Optional feature macro: UNCACHE_WBUF_EN (posted stores acknowledged from U_ACK, drained in background).
module uncache_req_ctrl
  import data_route_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ub_req,
  output logic        ub_wr,
  output logic [1:0]  ub_size,
  output logic [31:0] ub_addr,
  output logic [31:0] ub_wdata,
  output logic [3:0]  ub_wstrb,
  input  logic        ub_addr_ok,
  input  logic        ub_data_ok,
  input  logic [31:0] ub_rdata,
  output logic        idle,
  output logic        drain,
  output logic        resp,
  output logic [31:0] resp_rdata
);

  u_state_t state, state_nxt;
  mem_req_t lat;
  logic     posted;

`ifdef UNCACHE_WBUF_EN
  assign posted = lat.wr;
`else
  assign posted = 1'b0;
`endif

  // State register and request capture; the bus only ever sees the captured copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= U_IDLE;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (start && (state == U_IDLE))
        lat <= '{wr: wr, size: size, addr: addr, wdata: wdata, wstrb: wstrb};
    end
  end

  always_comb begin
    state_nxt  = state;
    ub_req     = 1'b0;
    idle       = 1'b0;
    drain      = 1'b0;
    resp       = 1'b0;
    resp_rdata = '0;
    case (state)
      U_IDLE: begin
        idle = 1'b1;
        if (start) begin
`ifdef UNCACHE_WBUF_EN
          state_nxt = wr ? U_ACK : U_REQ;
`else
          state_nxt = U_REQ;
`endif
        end
      end
      U_REQ: begin
        ub_req = 1'b1;
        drain  = posted;
        if (ub_addr_ok) state_nxt = U_WAIT;
      end
      U_WAIT: begin
        drain = posted;
        if (ub_data_ok) begin
          // A posted store was already acknowledged; its bus completion stays internal.
          resp       = !posted;
          resp_rdata = (!posted && !lat.wr) ? ub_rdata : '0;
          state_nxt  = U_IDLE;
        end
      end
`ifdef UNCACHE_WBUF_EN
      U_ACK: begin
        resp      = 1'b1;
        state_nxt = U_REQ;
      end
`endif
      default: state_nxt = U_IDLE;
    endcase
  end

  assign ub_wr    = lat.wr;
  assign ub_size  = lat.size;
  assign ub_addr  = lat.addr;
  assign ub_wdata = lat.wdata;
  assign ub_wstrb = lat.wstrb;

endmodule

// File: rtl/data_route_bridge.sv
// Routes translated CPU data requests to the data cache or the uncached bus, one transaction at a time.
// Optional feature macro: UNCACHE_WBUF_EN (posted uncached stores; cached traffic may overlap the drain).
module data_route_bridge
  import data_route_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  input  logic        cpu_no_dcache,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [1:0]  dc_size,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_wstrb,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata,
  output logic        ub_req,
  output logic        ub_wr,
  output logic [1:0]  ub_size,
  output logic [31:0] ub_addr,
  output logic [31:0] ub_wdata,
  output logic [3:0]  ub_wstrb,
  input  logic        ub_addr_ok,
  input  logic        ub_data_ok,
  input  logic [31:0] ub_rdata
);

  logic        pend;
  logic        u_idle, u_drain, u_resp;
  logic [31:0] u_rdata;
  logic        uc_start, dc_go, dc_resp;

  // Uncached accept needs a fully quiet bridge; cached may also overlap a posted-store drain.
  assign uc_start = cpu_req && cpu_no_dcache && u_idle && !pend;
  assign dc_go    = cpu_req && !cpu_no_dcache && !pend && (u_idle || u_drain);
  assign dc_resp  = pend && dc_data_ok;

  assign dc_req   = dc_go;
  assign dc_wr    = dc_go && cpu_wr;
  assign dc_size  = dc_go ? cpu_size  : '0;
  assign dc_addr  = dc_go ? cpu_addr  : '0;
  assign dc_wdata = dc_go ? cpu_wdata : '0;
  assign dc_wstrb = dc_go ? cpu_wstrb : '0;

  assign cpu_addr_ok = uc_start || (dc_go && dc_addr_ok);
  assign cpu_data_ok = dc_resp || u_resp;
  assign cpu_rdata   = dc_resp ? dc_rdata : u_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend <= 1'b0;
    else         pend <= (pend && !dc_data_ok) || (dc_go && dc_addr_ok);
  end

  uncache_req_ctrl u_ctrl (
    .clk        (clk),
    .resetn     (resetn),
    .start      (uc_start),
    .wr         (cpu_wr),
    .size       (cpu_size),
    .addr       (cpu_addr),
    .wdata      (cpu_wdata),
    .wstrb      (cpu_wstrb),
    .ub_req     (ub_req),
    .ub_wr      (ub_wr),
    .ub_size    (ub_size),
    .ub_addr    (ub_addr),
    .ub_wdata   (ub_wdata),
    .ub_wstrb   (ub_wstrb),
    .ub_addr_ok (ub_addr_ok),
    .ub_data_ok (ub_data_ok),
    .ub_rdata   (ub_rdata),
    .idle       (u_idle),
    .drain      (u_drain),
    .resp       (u_resp),
    .resp_rdata (u_rdata)
  );

endmodule

// File: tb/tb_data_route_bridge.sv
// Directed, table-driven bench for data_route_bridge; honours UNCACHE_WBUF_EN when defined.
module tb_data_route_bridge;

`ifdef UNCACHE_WBUF_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk, resetn;
  logic        cpu_req, cpu_wr, cpu_no_dcache;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        dc_req, dc_wr;
  logic [1:0]  dc_size;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        ub_req, ub_wr;
  logic [1:0]  ub_size;
  logic [31:0] ub_addr, ub_wdata;
  logic [3:0]  ub_wstrb;
  logic        ub_addr_ok, ub_data_ok;
  logic [31:0] ub_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_route_bridge dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_no_dcache(cpu_no_dcache),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .ub_req(ub_req), .ub_wr(ub_wr), .ub_size(ub_size), .ub_addr(ub_addr),
    .ub_wdata(ub_wdata), .ub_wstrb(ub_wstrb),
    .ub_addr_ok(ub_addr_ok), .ub_data_ok(ub_data_ok), .ub_rdata(ub_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        nodc;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          delay;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic nodc, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    cpu_req = req; cpu_no_dcache = nodc; cpu_wr = wr; cpu_size = 2'd2;
    cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
  endtask

  task automatic set_bus(input logic u_aok, input logic u_dok, input logic [31:0] u_rd,
                         input logic d_aok, input logic d_dok, input logic [31:0] d_rd);
    ub_addr_ok = u_aok; ub_data_ok = u_dok; ub_rdata = u_rd;
    dc_addr_ok = d_aok; dc_data_ok = d_dok; dc_rdata = d_rd;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_addr_ok"}, 32'(cpu_addr_ok), 32'h0);
    check({tag, "_cpu_data_ok"}, 32'(cpu_data_ok), 32'h0);
    check({tag, "_cpu_rdata"},   cpu_rdata,        32'h0);
    check({tag, "_dc_req"},      32'(dc_req),      32'h0);
    check({tag, "_ub_req"},      32'(ub_req),      32'h0);
    check({tag, "_ub_wr"},       32'(ub_wr),       32'h0);
    check({tag, "_ub_size"},     32'(ub_size),     32'h0);
    check({tag, "_ub_addr"},     ub_addr,          32'h0);
    check({tag, "_ub_wdata"},    ub_wdata,         32'h0);
    check({tag, "_ub_wstrb"},    32'(ub_wstrb),    32'h0);
  endtask

  // One transaction with the bench acting as both bus partners; CPU fields are scrambled after accept.
  task automatic run_vec(input vec_t v, input string name);
    int          acc = -1, rsp = -1, req_cnt = 0, n_dok = 0;
    bit          ub_hs = 1'b0, dc_hs = 1'b0, stable = 1'b1, zero_ok = 1'b1, bus_done;
    logic [31:0] rd = 32'h0;
    bus_done = !v.nodc;
    for (int k = 0; k < 40 && !(rsp >= 0 && bus_done); k++) begin
      @(negedge clk);
      if (acc < 0) set_cpu(1'b1, v.nodc, v.wr, v.addr, v.wdata, v.wstrb);
      else         set_cpu(1'b0, v.nodc, ~v.wr, ~v.addr, ~v.wdata, ~v.wstrb);
      cpu_size = (acc < 0) ? v.size : ~v.size;
      set_bus(ub_req && (req_cnt >= v.delay), ub_hs, v.rdata, 1'b1, dc_hs, v.rdata);
      ub_hs = 1'b0;
      dc_hs = 1'b0;
      #1;
      if (ub_data_ok) bus_done = 1'b1;
      if (acc < 0 && cpu_addr_ok) acc = k;
      if (cpu_data_ok) begin
        n_dok++;
        if (rsp < 0) begin rsp = k; rd = cpu_rdata; end
      end else if (cpu_rdata !== 32'h0) zero_ok = 1'b0;
      if (ub_req) begin
        req_cnt++;
        if (ub_addr !== v.addr || ub_wdata !== v.wdata || ub_wstrb !== v.wstrb ||
            ub_wr !== v.wr || ub_size !== v.size) stable = 1'b0;
        if (ub_addr_ok) ub_hs = 1'b1;
      end
      if (dc_req && dc_addr_ok) dc_hs = 1'b1;
    end
    check({name, "_accept_cycle"}, 32'(acc), 32'h0);
    check({name, "_latency"}, 32'(rsp - acc), 32'(v.exp_lat));
    check({name, "_rdata"}, rd, v.exp_rdata);
    check({name, "_data_ok_count"}, 32'(n_dok), 32'h1);
    check({name, "_rdata_zero_idle"}, 32'(zero_ok), 32'h1);
    if (v.nodc) check({name, "_ub_stable"}, 32'(stable), 32'h1);
    idle_cycle();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h1FAF_F000, 32'h0, 4'hF, 32'h1234_5678, 0, 2, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h1FAF_F004, 32'h0, 4'hF, 32'h0BAD_F00D, 3, 5, 32'h0BAD_F00D};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'hF, 32'hCAFE_0001, 0, 1, 32'hCAFE_0001};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h1FAF_F008, 32'hAABB_CCDD, 4'b0011, 32'h5555_AAAA, 0,
                POSTED ? 1 : 2, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h1FAF_F00B, 32'h0, 4'h8, 32'h0000_00EE, 1, 3, 32'h0000_00EE};
    vecs[5] = '{1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'h1357_9BDF, 4'hF, 32'h0000_0077, 0, 1, 32'h0000_0077};
    vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h1FAF_F00E, 32'h2468_0000, 4'b1100, 32'hFFFF_FFFF, 2,
                POSTED ? 1 : 4, 32'h0};

    resetn = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Cached load outstanding blocks an uncached request until the cycle after dc_data_ok.
    @(negedge clk); set_cpu(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    set_bus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    check("b2b_c0_dc_req", 32'(dc_req), 32'h1);
    check("b2b_c0_accept", 32'(cpu_addr_ok), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); set_cpu(1'b1, 1'b1, 1'b0, 32'h1FAF_F010, 32'h0, 4'hF);
      set_bus(1'b0, 1'b0, 32'h0, 1'b0, c == 3, 32'h1111_2222); #1;
      check($sformatf("b2b_c%0d_no_accept", c), 32'(cpu_addr_ok), 32'h0);
      check($sformatf("b2b_c%0d_data_ok", c), 32'(cpu_data_ok), 32'(c == 3));
    end
    check("b2b_c3_rdata", cpu_rdata, 32'h1111_2222);
    @(negedge clk); set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("b2b_c4_accept", 32'(cpu_addr_ok), 32'h1);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk); set_cpu(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
      set_bus(c == 6, c == 7, 32'h3333_4444, 1'b1, 1'b0, 32'h0); #1;
      check($sformatf("b2b_c%0d_dc_req_busy", c), 32'(dc_req), 32'h0);
      check($sformatf("b2b_c%0d_no_accept", c), 32'(cpu_addr_ok), 32'h0);
    end
    check("b2b_c7_data_ok", 32'(cpu_data_ok), 32'h1);
    check("b2b_c7_rdata", cpu_rdata, 32'h3333_4444);
    @(negedge clk); set_bus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    check("b2b_c8_dc_req", 32'(dc_req), 32'h1);
    check("b2b_c8_accept", 32'(cpu_addr_ok), 32'h1);
    @(negedge clk); set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_5555); #1;
    check("b2b_c9_data_ok", 32'(cpu_data_ok), 32'h1);
    check("b2b_c9_rdata", cpu_rdata, 32'h4444_5555);
    idle_cycle();

`ifdef UNCACHE_WBUF_EN
    // Posted store: early ack, cached load overlaps the drain, uncached load waits for it.
    @(negedge clk); set_cpu(1'b1, 1'b1, 1'b1, 32'h1FAF_F020, 32'hAABB_CCDD, 4'b0011);
    set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("wb_c0_accept", 32'(cpu_addr_ok), 32'h1);
    @(negedge clk); set_cpu(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
    set_bus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    check("wb_c1_data_ok", 32'(cpu_data_ok), 32'h1);
    check("wb_c1_no_accept", 32'(cpu_addr_ok), 32'h0);
    @(negedge clk); #1;
    check("wb_c2_ub_req", 32'(ub_req), 32'h1);
    check("wb_c2_dc_accept", 32'(cpu_addr_ok & dc_req), 32'h1);
    @(negedge clk); set_cpu(1'b1, 1'b1, 1'b0, 32'h1FAF_F024, 32'h0, 4'hF);
    set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5A5A_0000); #1;
    check("wb_c3_dc_data", cpu_rdata, 32'h5A5A_0000);
    check("wb_c3_no_accept", 32'(cpu_addr_ok), 32'h0);
    @(negedge clk); set_bus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("wb_c4_no_accept", 32'(cpu_addr_ok), 32'h0);
    @(negedge clk); set_bus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0); #1;
    check("wb_c5_no_data_ok", 32'(cpu_data_ok), 32'h0);
    check("wb_c5_no_accept", 32'(cpu_addr_ok), 32'h0);
    @(negedge clk); set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("wb_c6_accept", 32'(cpu_addr_ok), 32'h1);
    @(negedge clk); set_cpu(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    @(negedge clk); set_bus(1'b0, 1'b1, 32'h9999_8888, 1'b0, 1'b0, 32'h0); #1;
    check("wb_c8_data_ok", 32'(cpu_data_ok), 32'h1);
    check("wb_c8_rdata", cpu_rdata, 32'h9999_8888);
    idle_cycle();
`endif

    // Async reset while waiting for the uncached response, then a clean transaction.
    @(negedge clk); set_cpu(1'b1, 1'b1, 1'b0, 32'h1FAF_F030, 32'h0, 4'hF); #1;
    check("rst_accept", 32'(cpu_addr_ok), 32'h1);
    @(negedge clk); set_cpu(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("rst_ub_req", 32'(ub_req), 32'h1);
    @(negedge clk); set_bus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2; resetn = 1'b0; ub_data_ok = 1'b1; ub_rdata = 32'h7777_7777;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk); resetn = 1'b1; ub_data_ok = 1'b0;
    run_vec(vecs[0], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
